calc_requester: RTL and testbench
=================================

CALC_REQUESTER -- requirements
Module: calc_requester

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 2, meaning the cycles from driving the calc port to sampling its result; legal range 1..15.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-003 The block SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-004 The block SHALL have port req_valid, input, 1, meaning the request operands are valid.
REQ-005 The block SHALL have port req_ready, output, 1, meaning the block can accept a request.
REQ-006 The block SHALL have ports req_a, req_b and req_c, input, 8 each, meaning the operands A, B and C.
REQ-007 The block SHALL have port req_op, input, 2, with encoding 00 = A+B+C, 01 = -A+B+C, 10 = A-B+C, 11 = A+B-C.
REQ-008 The block SHALL have ports calc_a, calc_b and calc_c, output, 8 each, meaning the registered operands driven to the calculator.
REQ-009 The block SHALL have port calc_op, output, 2, meaning the registered op driven to the calculator.
REQ-010 The block SHALL have port calc_res, input, 8, meaning the calculator result.
REQ-011 The block SHALL have port calc_cout, input, 1, meaning the calculator carry-out.
REQ-012 The block SHALL have port resp_valid, output, 1, meaning the response is valid.
REQ-013 The block SHALL have port resp_ready, input, 1, meaning the consumer accepts the response.
REQ-014 The block SHALL have port resp_res, output, 8, meaning the captured calc_res.
REQ-015 The block SHALL have port resp_cout, output, 1, meaning the captured calc_cout.
REQ-016 The block SHALL have port resp_mismatch, output, 1, meaning the checker flag for the current response.
REQ-017 The block SHALL have port txn_count, output, 16, counting completed responses.
REQ-018 The block SHALL have port err_count, output, 8, counting mismatched responses.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, SETTLE and RESP.
REQ-020 The FSM SHALL assert req_ready only in IDLE; req_ready SHALL be registered-state-decoded, with no combinational path from resp_ready.
REQ-021 In IDLE, req_valid && req_ready at edge T SHALL load calc_a/b/c/op from req_* at edge T, load the settle counter with SETTLE_CYCLES-1, and move to SETTLE.
REQ-022 In SETTLE, the counter SHALL decrement each cycle; at the edge where it equals 0, the block SHALL capture calc_res/calc_cout into resp_res/resp_cout, set resp_valid and move to RESP.
REQ-023 resp_valid SHALL therefore first be high in the cycle following edge T+SETTLE_CYCLES.
REQ-024 In RESP, resp_valid, resp_res, resp_cout and resp_mismatch SHALL hold stable until resp_valid && resp_ready.
REQ-025 On the response handshake edge, the block SHALL clear resp_valid, return to IDLE and increment txn_count.
REQ-026 The earliest next acceptance SHALL be one cycle after the response handshake; there is no same-cycle response-and-request.
REQ-027 calc_a/b/c/op SHALL hold their last loaded values in all states; they change only on acceptance.
REQ-028 req_valid in SETTLE or RESP SHALL be ignored, and the requester SHALL hold its payload.
REQ-029 txn_count SHALL saturate at 16'hFFFF.
REQ-030 err_count SHALL saturate at 8'hFF.
REQ-031 resp_ready asserted while resp_valid is low SHALL have no effect.

Reset
REQ-032 While rst is high at an edge, the block SHALL force state to IDLE, req_ready=1 after the edge, resp_valid=0, calc_a/b/c=0, calc_op=0, resp_res=0, resp_cout=0, resp_mismatch=0, txn_count=0 and err_count=0.
REQ-033 Reset during SETTLE or RESP SHALL abandon the transaction with no response and no count update.

Configuration
REQ-034 With macro CALC_REQUESTER_CHECK_EN defined, the block SHALL compute expected = sum of the three operands modulo 256 at acceptance, with the operand selected by req_op two's-complement negated.
REQ-035 With CALC_REQUESTER_CHECK_EN defined, at capture the block SHALL set resp_mismatch = (calc_res != expected) and increment err_count at the handshake when resp_mismatch is 1; calc_cout is not checked.
REQ-036 With CALC_REQUESTER_CHECK_EN undefined, resp_mismatch and err_count SHALL be tied to 0, with no checker logic or expected register present.

Verification
REQ-037 The bench SHALL cover: SETTLE_CYCLES=2, op=00, A=3, B=4, C=5, ideal calc model -> resp_valid high 2 cycles after acceptance, resp_res=12, resp_mismatch=0, txn_count=1.
REQ-038 The bench SHALL cover: op=01, A=1, B=10, C=0 -> resp_res=9; op=11, A=0, B=0, C=1 -> resp_res=8'hFF.
REQ-039 The bench SHALL cover: resp_ready held low 5 cycles after resp_valid -> resp_valid and payload stable, req_ready=0, req_valid pulses ignored, single txn_count increment.
REQ-040 The bench SHALL cover: rst pulsed 1 cycle during SETTLE -> no resp_valid, all outputs at reset values, req_ready=1 the following cycle.
REQ-041 The bench SHALL cover, with CALC_REQUESTER_CHECK_EN: calc model forced to return 8'h00 for A=B=C=1, op=00 -> resp_mismatch=1, err_count=1 after the handshake; without the macro -> resp_mismatch=0, err_count=0.
REQ-042 The bench SHALL cover: back-to-back requests with req_valid held high -> acceptance exactly one cycle after each response handshake, calc_* updated only on acceptance.

Source files
------------

// File: rtl/calc_requester_if.sv
// Bundle of request, calculator and response signals for calc_requester.
// slave is the requester's view; master is the view of the surrounding environment.
interface calc_requester_if;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_a;
    logic [7:0]  req_b;
    logic [7:0]  req_c;
    logic [1:0]  req_op;
    logic [7:0]  calc_a;
    logic [7:0]  calc_b;
    logic [7:0]  calc_c;
    logic [1:0]  calc_op;
    logic [7:0]  calc_res;
    logic        calc_cout;
    logic        resp_valid;
    logic        resp_ready;
    logic [7:0]  resp_res;
    logic        resp_cout;
    logic        resp_mismatch;
    logic [15:0] txn_count;
    logic [7:0]  err_count;

    modport slave (
        input  req_valid, req_a, req_b, req_c, req_op,
        output req_ready,
        output calc_a, calc_b, calc_c, calc_op,
        input  calc_res, calc_cout,
        output resp_valid, resp_res, resp_cout, resp_mismatch,
        input  resp_ready,
        output txn_count, err_count
    );

    modport master (
        output req_valid, req_a, req_b, req_c, req_op,
        input  req_ready,
        input  calc_a, calc_b, calc_c, calc_op,
        output calc_res, calc_cout,
        input  resp_valid, resp_res, resp_cout, resp_mismatch,
        output resp_ready,
        input  txn_count, err_count
    );
endinterface

// File: rtl/calc_requester.sv
// Drives one operand set to an external calculator, waits SETTLE_CYCLES, then returns its result.
// Define CALC_REQUESTER_CHECK_EN to add the result checker (resp_mismatch / err_count).
module calc_requester #(
    parameter int SETTLE_CYCLES = 2
) (
    input logic          clk,
    input logic          rst,
    calc_requester_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_e;

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  calc_a_q, calc_a_d, calc_b_q, calc_b_d, calc_c_q, calc_c_d;
    logic [1:0]  calc_op_q, calc_op_d;
    logic [7:0]  resp_res_q, resp_res_d;
    logic        resp_cout_q, resp_cout_d;
    logic [15:0] txn_count_q, txn_count_d;
    logic        accept, capture, resp_hs;

    assign accept  = (state_q == IDLE) && bus.req_valid;
    assign capture = (state_q == SETTLE) && (cnt_q == 4'd0);
    assign resp_hs = (state_q == RESP) && bus.resp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            calc_a_q    <= 8'd0;
            calc_b_q    <= 8'd0;
            calc_c_q    <= 8'd0;
            calc_op_q   <= 2'd0;
            resp_res_q  <= 8'd0;
            resp_cout_q <= 1'b0;
            txn_count_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            calc_a_q    <= calc_a_d;
            calc_b_q    <= calc_b_d;
            calc_c_q    <= calc_c_d;
            calc_op_q   <= calc_op_d;
            resp_res_q  <= resp_res_d;
            resp_cout_q <= resp_cout_d;
            txn_count_q <= txn_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.req_valid) state_d = SETTLE;
            SETTLE:  if (cnt_q == 4'd0) state_d = RESP;
            RESP:    if (bus.resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decode registered state only, so resp_ready never reaches req_ready.
    always_comb begin
        bus.req_ready  = (state_q == IDLE);
        bus.resp_valid = (state_q == RESP);
    end

    always_comb begin
        cnt_d       = cnt_q;
        calc_a_d    = calc_a_q;
        calc_b_d    = calc_b_q;
        calc_c_d    = calc_c_q;
        calc_op_d   = calc_op_q;
        resp_res_d  = resp_res_q;
        resp_cout_d = resp_cout_q;
        txn_count_d = txn_count_q;
        if (accept) begin
            cnt_d     = SETTLE_INIT;
            calc_a_d  = bus.req_a;
            calc_b_d  = bus.req_b;
            calc_c_d  = bus.req_c;
            calc_op_d = bus.req_op;
        end else if (state_q == SETTLE && cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
        if (capture) begin
            resp_res_d  = bus.calc_res;
            resp_cout_d = bus.calc_cout;
        end
        if (resp_hs && txn_count_q != 16'hFFFF)
            txn_count_d = txn_count_q + 16'd1;
    end

    assign bus.calc_a    = calc_a_q;
    assign bus.calc_b    = calc_b_q;
    assign bus.calc_c    = calc_c_q;
    assign bus.calc_op   = calc_op_q;
    assign bus.resp_res  = resp_res_q;
    assign bus.resp_cout = resp_cout_q;
    assign bus.txn_count = txn_count_q;

`ifdef CALC_REQUESTER_CHECK_EN
    logic [7:0] exp_q, exp_d;
    logic       mismatch_q, mismatch_d;
    logic [7:0] err_count_q, err_count_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            exp_q       <= 8'd0;
            mismatch_q  <= 1'b0;
            err_count_q <= 8'd0;
        end else begin
            exp_q       <= exp_d;
            mismatch_q  <= mismatch_d;
            err_count_q <= err_count_d;
        end
    end

    // Expected value is fixed at acceptance; the negated operand follows req_op.
    always_comb begin
        exp_d       = exp_q;
        mismatch_d  = mismatch_q;
        err_count_d = err_count_q;
        if (accept) begin
            case (bus.req_op)
                2'b01:   exp_d = bus.req_b + bus.req_c - bus.req_a;
                2'b10:   exp_d = bus.req_a - bus.req_b + bus.req_c;
                2'b11:   exp_d = bus.req_a + bus.req_b - bus.req_c;
                default: exp_d = bus.req_a + bus.req_b + bus.req_c;
            endcase
        end
        if (capture)
            mismatch_d = (bus.calc_res != exp_q);
        if (resp_hs && mismatch_q && err_count_q != 8'hFF)
            err_count_d = err_count_q + 8'd1;
    end

    assign bus.resp_mismatch = mismatch_q;
    assign bus.err_count     = err_count_q;
`else
    assign bus.resp_mismatch = 1'b0;
    assign bus.err_count     = 8'd0;
`endif
endmodule

// File: tb/tb_calc_requester.sv
// Directed bench for calc_requester with an ideal (optionally forced-zero) calculator model.
module tb_calc_requester;
    localparam int SC = 2;

    logic clk = 1'b0;
    logic rst;
    logic force_zero;
    int   n_asrt = 0;
    int   n_fail = 0;
    int   lat;
    logic [9:0] sum;

    calc_requester_if bus ();

    calc_requester #(.SETTLE_CYCLES(SC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (bus.calc_op)
            2'b01:   sum = {2'b0, bus.calc_b} + {2'b0, bus.calc_c} - {2'b0, bus.calc_a};
            2'b10:   sum = {2'b0, bus.calc_a} - {2'b0, bus.calc_b} + {2'b0, bus.calc_c};
            2'b11:   sum = {2'b0, bus.calc_a} + {2'b0, bus.calc_b} - {2'b0, bus.calc_c};
            default: sum = {2'b0, bus.calc_a} + {2'b0, bus.calc_b} + {2'b0, bus.calc_c};
        endcase
        bus.calc_res  = force_zero ? 8'h00 : sum[7:0];
        bus.calc_cout = sum[8];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_asrt++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic send(input logic [7:0] a, b, c, input logic [1:0] op);
        bus.req_valid = 1'b1;
        bus.req_a = a; bus.req_b = b; bus.req_c = c; bus.req_op = op;
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int l);
        l = 0;
        while (!bus.resp_valid && l < 20) begin
            tick();
            l++;
        end
        chk("latency", 32'(l), 32'(SC));
    endtask

    task automatic handshake();
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; force_zero = 1'b0;
        bus.req_valid = 1'b0; bus.req_a = 8'd0; bus.req_b = 8'd0; bus.req_c = 8'd0;
        bus.req_op = 2'd0; bus.resp_ready = 1'b0;
        tick(); tick();
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_calc", {bus.calc_a, bus.calc_b, bus.calc_c, 6'd0, bus.calc_op}, 0);
        chk("rst_resp_res", bus.resp_res, 0);
        chk("rst_resp_cout", bus.resp_cout, 0);
        chk("rst_mismatch", bus.resp_mismatch, 0);
        chk("rst_txn", bus.txn_count, 0);
        chk("rst_err", bus.err_count, 0);
        rst = 1'b0;

        // resp_ready while idle must do nothing
        bus.resp_ready = 1'b1;
        tick(); tick();
        chk("idle_rdy_valid", bus.resp_valid, 0);
        chk("idle_rdy_txn", bus.txn_count, 0);
        bus.resp_ready = 1'b0;

        // basic op 00
        send(8'd3, 8'd4, 8'd5, 2'b00);
        chk("acc_req_ready", bus.req_ready, 0);
        chk("acc_calc_a", bus.calc_a, 3);
        chk("acc_resp_valid", bus.resp_valid, 0);
        wait_resp(lat);
        chk("t1_res", bus.resp_res, 12);
        chk("t1_cout", bus.resp_cout, 0);
        chk("t1_mismatch", bus.resp_mismatch, 0);
        handshake();
        chk("t1_valid_clr", bus.resp_valid, 0);
        chk("t1_txn", bus.txn_count, 1);
        chk("t1_req_ready", bus.req_ready, 1);

        send(8'd1, 8'd10, 8'd0, 2'b01);
        wait_resp(lat);
        chk("op01_res", bus.resp_res, 8'd9);
        handshake();
        send(8'd0, 8'd0, 8'd1, 2'b11);
        wait_resp(lat);
        chk("op11_res", bus.resp_res, 8'hFF);
        handshake();
        send(8'd20, 8'd5, 8'd1, 2'b10);
        wait_resp(lat);
        chk("op10_res", bus.resp_res, 8'h10);
        handshake();
        chk("txn_after_4", bus.txn_count, 4);

        // stall with resp_ready low; stray request pulses must be ignored
        send(8'd2, 8'd2, 8'd2, 2'b00);
        wait_resp(lat);
        for (int i = 0; i < 5; i++) begin
            bus.req_valid = i[0]; bus.req_a = 8'd99; bus.req_b = 8'd99;
            tick();
            chk("stall_valid", bus.resp_valid, 1);
            chk("stall_res", bus.resp_res, 6);
            chk("stall_req_ready", bus.req_ready, 0);
            chk("stall_calc_a", bus.calc_a, 2);
        end
        bus.req_valid = 1'b0;
        handshake();
        chk("stall_txn", bus.txn_count, 5);
        tick();
        chk("stall_no_accept", bus.calc_a, 2);

        // reset mid-SETTLE abandons the transaction
        send(8'd7, 8'd7, 8'd7, 2'b00);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", bus.resp_valid, 0);
        chk("mid_rst_calc_a", bus.calc_a, 0);
        chk("mid_rst_res", bus.resp_res, 0);
        chk("mid_rst_txn", bus.txn_count, 0);
        chk("mid_rst_req_ready", bus.req_ready, 1);
        tick(); tick(); tick();
        chk("post_rst_valid", bus.resp_valid, 0);
        chk("post_rst_req_ready", bus.req_ready, 1);

        // wrong calculator result
        force_zero = 1'b1;
        send(8'd1, 8'd1, 8'd1, 2'b00);
        wait_resp(lat);
        chk("bad_res", bus.resp_res, 0);
`ifdef CALC_REQUESTER_CHECK_EN
        chk("bad_mismatch", bus.resp_mismatch, 1);
        handshake();
        chk("bad_err", bus.err_count, 1);
`else
        chk("bad_mismatch", bus.resp_mismatch, 0);
        handshake();
        chk("bad_err", bus.err_count, 0);
`endif
        chk("bad_txn", bus.txn_count, 1);
        force_zero = 1'b0;

        // back-to-back with req_valid held high
        bus.req_valid = 1'b1;
        bus.req_a = 8'd10; bus.req_b = 8'd1; bus.req_c = 8'd1; bus.req_op = 2'b00;
        tick();
        chk("b2b_acc1", bus.calc_a, 10);
        bus.req_a = 8'd20;
        wait_resp(lat);
        chk("b2b_hold_calc", bus.calc_a, 10);
        chk("b2b_res1", bus.resp_res, 12);
        handshake();
        chk("b2b_hs_ready", bus.req_ready, 1);
        chk("b2b_hs_calc", bus.calc_a, 10);
        tick();
        chk("b2b_acc2", bus.calc_a, 20);
        chk("b2b_acc2_ready", bus.req_ready, 0);
        bus.req_valid = 1'b0;
        wait_resp(lat);
        chk("b2b_res2", bus.resp_res, 22);
        handshake();
        chk("b2b_txn", bus.txn_count, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
